// File: rtl/posit_data_extraction.sv
`default_nettype none
// ============================================================================
// Module      : posit_data_extraction
// Description : Iterative posit field decoder. It scans the regime one bit per
//               cycle and produces the sign, regime, exponent and mantissa.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_data_extraction #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       In,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               Sign,
  output logic [N-2:0]       InRemain,
  output logic signed [RS:0] RegimeValue,
  output logic [ES-1:0]      Exponent,
  output logic [N-ES+2:0]    Mantissa,
  output logic               Zero,
  output logic               NaR
);

  localparam int PW = $clog2(N);
  localparam int FW = N - 1 - ES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-2:0]  r_rem;
  logic          r_lead;
  logic [PW-1:0] r_pos;
  logic [RS-1:0] r_run;

  logic [N-2:0]  w_mag;
  logic          w_zero;
  logic          w_nar;
  logic          w_term;
  logic          w_last;
  logic [RS-1:0] w_run_fin;
  logic [RS:0]   w_run_ext;
  logic [RS:0]   w_regime;
  logic [PW-1:0] w_shamt;
  logic [N-2:0]  w_tail;

  // Low N-1 bits of -In equal the two's complement of the low N-1 bits alone.
  assign w_mag  = In[N-1] ? (~In[N-2:0] + 1'b1) : In[N-2:0];
  assign w_zero = (In == '0);
  assign w_nar  = (In == {1'b1, {(N-1){1'b0}}});

  assign w_term    = (r_rem[r_pos] != r_lead);
  assign w_last    = w_term || (r_pos == '0);
  assign w_run_fin = w_term ? r_run : r_run + 1'b1;
  assign w_run_ext = {1'b0, w_run_fin};
  assign w_regime  = r_lead ? (w_run_ext - 1'b1) : (-w_run_ext);

  // Left-align the bits below the terminator; an exhausted run leaves none.
  assign w_shamt = PW'(N - 1) - r_pos;
  assign w_tail  = w_term ? (r_rem << w_shamt) : '0;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign InRemain  = r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_lead      <= 1'b0;
      r_pos       <= '0;
      r_run       <= '0;
      Sign        <= 1'b0;
      RegimeValue <= '0;
      Exponent    <= '0;
      Mantissa    <= '0;
      Zero        <= 1'b0;
      NaR         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            Sign        <= In[N-1];
            r_rem       <= w_mag;
            r_lead      <= w_mag[N-2];
            r_run       <= RS'(1);
            r_pos       <= PW'(N - 3);
            Zero        <= w_zero;
            NaR         <= w_nar;
            RegimeValue <= '0;
            Exponent    <= '0;
            Mantissa    <= '0;
            r_state     <= (w_zero || w_nar) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_last) begin
            r_run       <= w_run_fin;
            RegimeValue <= w_regime;
            Exponent    <= w_tail[N-2 -: ES];
            Mantissa    <= {1'b1, w_tail[FW-1:0], 3'b000};
            r_state     <= S_DONE;
          end else begin
            r_run <= r_run + 1'b1;
            r_pos <= r_pos - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/posit_data_extraction.md
# posit_data_extraction

Iterative posit field decoder feeding the posit adder arithmetic stage. It accepts one N-bit posit over a valid/ready handshake and strips the sign. It then scans the regime run one bit per cycle and presents Sign, InRemain, RegimeValue, Exponent and Mantissa in exactly the widths the arithmetic stage consumes, plus Zero/NaR flags. Two instances, one per operand, sit directly upstream of the arithmetic stage.

## Interface
- N, 8, posit word width
- ES, 3, exponent field width
- RS, log2(N), regime value magnitude width; RegimeValue is RS+1 bits signed
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- In  input  N  posit operand
- in_valid  input  1  In is valid
- in_ready  output  1  block can accept In
- out_valid  output  1  decoded fields valid
- out_ready  input  1  consumer takes decoded fields
- Sign  output  1  In[N-1]
- InRemain  output  N-1  magnitude bits: two's complement of In when Sign=1, then drop MSB
- RegimeValue  output  RS+1 signed  regime k
- Exponent  output  ES  exponent field
- Mantissa  output  N-ES+3  {1'b1, fraction left-aligned, zero fill}
- Zero  output  1  In == 0
- NaR  output  1  In == {1'b1, (N-1)'b0}

## Operation
- States: IDLE, SCAN, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE, in_valid=1:
  - Capture Sign = In[N-1].
  - Capture rem = Sign ? (-In)[N-2:0] : In[N-2:0], and register it as InRemain.
  - Set lead = rem[N-2], run = 1, pos = N-3.
  - If In is zero or NaR: set the matching flag, force RegimeValue, Exponent and Mantissa to 0, and go to DONE.
  - Otherwise go to SCAN.
- SCAN, one bit per cycle:
  - rem[pos] == lead and pos > 0: run++, pos--, stay in SCAN.
  - rem[pos] != lead: this is the terminator. Go to DONE.
  - rem[pos] == lead and pos == 0: run++. The run is exhausted (run = N-1, no terminator). Go to DONE.
- On leaving SCAN, compute:
  - RegimeValue = lead ? run-1 : -run.
  - Field bits are those below the terminator (none if the run was exhausted).
  - Exponent = next ES field bits MSB-first. If fewer than ES bits remain, zero-fill the LSBs.
  - Mantissa = {1, remaining bits left-aligned, zeros}.
- DONE: outputs held stable while out_valid=1. When out_ready=1, go to IDLE.
- Range: RegimeValue spans -(N-1)..N-2 and fits RS+1 bits for power-of-two N.
- Exponent/fraction bits beyond the word are zero, never X.

## Timing
- Reset: state=IDLE, in_ready=1 in the cycle after reset deasserts.
- Reset value of every registered output is 0: out_valid, Sign, InRemain, RegimeValue, Exponent, Mantissa, Zero, NaR.
- Reset asserted in any state takes priority over all other inputs. It aborts a scan: no out_valid, no partial output.
- Accept occurs on an edge with in_valid & in_ready.
- Zero/NaR: out_valid is asserted the cycle after accept.
- Terminated run of length r: SCAN lasts r cycles. out_valid is asserted r+1 cycles after accept.
- Exhausted run: SCAN lasts N-2 cycles. out_valid is asserted N-1 cycles after accept.
- The DONE→IDLE edge consumes the result. in_ready rises the cycle after out_ready is seen, so there is no same-cycle accept.
- Throughput: one operand in flight; the next accept is at least 1 cycle after consume.
- in_valid while in_ready=0 is ignored, and In is not sampled.
- out_ready while out_valid=0 has no effect.

## Test plan
Parameters N=8, ES=3 for all scenarios.
- In=0x40 → Sign=0, InRemain=0x40, RegimeValue=0, Exponent=0, Mantissa=0x80; out_valid 2 cycles after accept.
- In=0x2B → InRemain=0x2B, RegimeValue=-1, Exponent=3'b010, Mantissa=0xE0; latency 2. In=0x5A → RegimeValue=0, Exponent=3'b110, Mantissa=0xC0.
- In=0x7F → RegimeValue=6, Exponent=0, Mantissa=0x80; out_valid 7 cycles after accept. In=0x01 → RegimeValue=-6, Exponent=0; latency 7.
- In=0xC0 → Sign=1, InRemain=0x40, RegimeValue=0, Exponent=0; latency 2. In=0x00 → Zero=1, latency 1. In=0x80 → NaR=1, Sign=1, latency 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, and a new in_valid is ignored; out_ready=1 → in_ready=1 the next cycle.
- Reset mid-operation: accept 0x7F, assert reset on the 3rd SCAN cycle → next cycle state IDLE, all outputs 0, and no out_valid.
